lab4_g41_p5_alu_arb: RTL
========================

LAB4_G41_P5_ALU_ARB -- requirements
Module: lab4_g41_p5_alu_arb

Interface
REQ-001 Parameter: CNT_W, default 16, width of the per-requester issue counters.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid, req1_valid  input  1 each  requester has an operation pending.
REQ-005 req0_ready, req1_ready  output  1 each  operation accepted this cycle (grant).
REQ-006 req0_a, req0_b, req1_a, req1_b  input  32 each  operands.
REQ-007 req0_op, req1_op  input  4 each  ALU opcode.
REQ-008 rsp0_valid, rsp1_valid  output  1 each  one-cycle result pulse to the owning requester.
REQ-009 rsp_s  output  32  shared result bus; meaningful only while a rsp*_valid is high.
REQ-010 rsp_n, rsp_z, rsp_v, rsp_c, rsp_hata  output  1 each  shared flags, same qualification.
REQ-011 cnt0, cnt1  output  CNT_W each  saturating count of accepted operations per requester.
REQ-012 busy  output  1  high while any issued operation has not yet produced its response.

Function
REQ-013 Block SHALL share one registered ALU (2-cycle latency: operand register, result register) between two requesters.
REQ-014 Handshake: transfer occurs when reqX_valid && reqX_ready in the same cycle; at most one ready high per cycle.
REQ-015 readyX SHALL be combinational from valids and arbiter state; requester may not drop valid before transfer.
REQ-016 Default arbitration: round-robin; last-granted pointer toggles to the other requester after each grant; with one valid, that requester is granted regardless of pointer.
REQ-017 ALU accepts one op per cycle; arbiter SHALL never stall for lack of ALU capacity (no backpressure on responses).
REQ-018 Granted operands/op SHALL drive ALU inputs the same cycle; idle cycles drive a=0, b=0, op=0.
REQ-019 Tag pipeline: 2 stages of {valid, id} aligned to ALU latency; op granted in cycle T yields rspID_valid=1 in cycle T+2 exactly, with rsp_* from the ALU.
REQ-020 Back-to-back grants SHALL produce back-to-back responses in grant order, no loss or reordering.
REQ-021 cntX increments by 1 per accepted op; holds at 2^CNT_W-1 (no wrap).
REQ-022 busy = OR of tag pipeline valid bits.
REQ-023 rsp0_valid and rsp1_valid SHALL never be high together.

Reset
REQ-024 On rst: ready outputs 0, rsp*_valid 0, tag pipeline cleared, RR pointer = requester 1 (so requester 0 wins first contention), cnt0=cnt1=0, busy=0.
REQ-025 Reset mid-operation: in-flight ops are discarded; no rsp*_valid asserts for them after rst deasserts, even though ALU data registers (unreset) still hold values.
REQ-026 rsp_s and flags are undefined-but-ignored after reset until first rsp*_valid.

Configuration
REQ-027 Macro ALU_ARB_PRIO_EN: defined -> fixed priority, requester 0 always wins contention, pointer logic removed; undefined -> round-robin per REQ-016.

Structure
REQ-028 Package lab4_g41_alu_pkg SHALL hold: ALU_LAT=2, opcode constants (ALU_ADD=4'b0000, ALU_SUB=4'b0001, ...), requester-id typedef (1 bit), tag struct {valid, id}.
REQ-029 Sub-module: one instance of lab4_g41_p4_alu; arbitration, tag pipeline and counters stay in this module.

Verification
REQ-030 Single op: req0 a=5, b=3, op=ALU_ADD at T -> ready0=1 at T; rsp0_valid=1 at T+2, rsp_s=8, z=0, c=0; rsp1_valid=0 throughout.
REQ-031 Contention after reset: both valid for 4 cycles -> grants 0,1,0,1; responses on rsp0,rsp1,rsp0,rsp1 at T+2..T+5; cnt0=cnt1=2.
REQ-032 With ALU_ARB_PRIO_EN: both valid 4 cycles -> all grants to 0, ready1=0; cnt0=4, cnt1=0.
REQ-033 Flags: req1 a=32'h7FFFFFFF, b=1, ALU_ADD -> rsp1_valid at T+2, rsp_s=32'h80000000, n=1, v=1; a=b=0, ALU_SUB -> z=1.
REQ-034 Reset mid-flight: grant at T, rst at T+1 -> no rsp*_valid at T+2 or later, busy=0, counters 0.
REQ-035 Saturation (CNT_W=2): 5 req0 ops -> cnt0 reaches 3 and holds.

Source files
------------

// File: rtl/lab4_g41_alu_pkg.sv
// Shared types and constants for the two-requester ALU arbiter slice.
// Holds the ALU latency, the opcode map, the requester id type, the tag
// carried alongside each in-flight operation, and the ALU request/response
// structs.
package lab4_g41_alu_pkg;

   localparam int ALU_LAT = 2;   // operand register + result register
   localparam int DATA_W  = 32;
   localparam int NUM_REQ = 2;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLL = 4'b0101;
   localparam logic [3:0] ALU_SRL = 4'b0110;
   localparam logic [3:0] ALU_SRA = 4'b0111;

   typedef logic [0:0] req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } tag_t;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [3:0]        op;
   } alu_req_t;

   typedef struct packed {
      logic [DATA_W-1:0] s;
      logic              n;
      logic              z;
      logic              v;
      logic              c;
      logic              hata;   // opcode not recognised
   } alu_rsp_t;

   // Opcodes 0..7 are defined; anything above raises hata.
   function automatic logic op_legal(input logic [3:0] op);
      return (op <= ALU_SRA);
   endfunction

endpackage

// File: rtl/lab4_g41_p4_alu.sv
// Two-stage registered ALU: operands are captured on one edge, the result
// and flags on the next, so an op presented in cycle T appears at T+2.
// Data registers have no reset; the owner qualifies the outputs.
// Ports:
//   clk    - clock
//   req_i  - operands and opcode (zero when idle)
//   rsp_o  - registered result and flags {s, n, z, v, c, hata}
// SUB sets c as the carry out of a + ~b + 1 (c=1 means no borrow).
module lab4_g41_p4_alu
   import lab4_g41_alu_pkg::*;
(
   input  logic     clk,
   input  alu_req_t req_i,
   output alu_rsp_t rsp_o
);

   alu_req_t          req_q;
   alu_rsp_t          rsp_d, rsp_q;
   logic              is_sub;
   logic [DATA_W-1:0] b_x;
   logic [DATA_W:0]   sum;

   always_ff @(posedge clk) begin
      req_q <= req_i;
      rsp_q <= rsp_d;
   end

   always_comb begin
      is_sub = (req_q.op == ALU_SUB);
      b_x    = is_sub ? ~req_q.b : req_q.b;
      sum    = {1'b0, req_q.a} + {1'b0, b_x} + {{DATA_W{1'b0}}, is_sub};
      rsp_d  = '0;
      case (req_q.op)
         ALU_ADD, ALU_SUB: begin
            rsp_d.s = sum[DATA_W-1:0];
            rsp_d.c = sum[DATA_W];
            // Signed overflow: both addends agree in sign, result does not.
            rsp_d.v = (req_q.a[DATA_W-1] == b_x[DATA_W-1]) &&
                      (sum[DATA_W-1] != req_q.a[DATA_W-1]);
         end
         ALU_AND: rsp_d.s = req_q.a & req_q.b;
         ALU_OR:  rsp_d.s = req_q.a | req_q.b;
         ALU_XOR: rsp_d.s = req_q.a ^ req_q.b;
         ALU_SLL: rsp_d.s = req_q.a << req_q.b[4:0];
         ALU_SRL: rsp_d.s = req_q.a >> req_q.b[4:0];
         ALU_SRA: rsp_d.s = DATA_W'($signed(req_q.a) >>> req_q.b[4:0]);
         default: rsp_d.hata = 1'b1;
      endcase
      if (op_legal(req_q.op)) begin
         rsp_d.n = rsp_d.s[DATA_W-1];
         rsp_d.z = (rsp_d.s == '0);
      end
   end

   assign rsp_o = rsp_q;

endmodule

// File: rtl/lab4_g41_p5_alu_arb.sv
// Two requesters sharing one 2-cycle ALU. A combinational arbiter grants at
// most one requester per cycle, the granted operands feed the ALU that same
// cycle, and a {valid,id} tag pipeline of ALU_LAT stages steers the result
// back as a one-cycle rspX_valid pulse. Saturating per-requester counters
// track accepted operations.
// Configuration macro ALU_ARB_PRIO_EN: defined -> fixed priority to
// requester 0; undefined -> round-robin with a last-granted pointer.
// Ports:
//   clk, rst                 - clock, async active-high reset
//   reqX_valid/ready         - request handshake (ready is the grant)
//   reqX_a, reqX_b, reqX_op  - operands and opcode
//   rsp0_valid, rsp1_valid   - result pulse to the owning requester
//   rsp_s, rsp_n/z/v/c/hata  - shared result and flags
//   cnt0, cnt1               - saturating accepted-op counters
//   busy                     - any op still in the tag pipeline
module lab4_g41_p5_alu_arb
   import lab4_g41_alu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic              req1_valid,
   output logic              req0_ready,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [3:0]        req0_op,
   input  logic [3:0]        req1_op,
   output logic              rsp0_valid,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp_s,
   output logic              rsp_n,
   output logic              rsp_z,
   output logic              rsp_v,
   output logic              rsp_c,
   output logic              rsp_hata,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1,
   output logic              busy
);

   logic [NUM_REQ-1:0] vld, grant, grant_raw;

   assign vld = {req1_valid, req0_valid};

   // ---------------- arbitration ----------------
`ifdef ALU_ARB_PRIO_EN
   always_comb begin
      grant_raw    = '0;
      grant_raw[0] = vld[0];
      grant_raw[1] = vld[1] & ~vld[0];
   end
`else
   // ptr_q remembers the last winner; on contention the other one wins.
   req_id_t ptr_q, ptr_d;

   always_comb begin
      if (&vld) grant_raw = ptr_q[0] ? 2'b01 : 2'b10;
      else      grant_raw = vld;
      ptr_d = ptr_q;
      if (|grant_raw) ptr_d = req_id_t'(grant_raw[1]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= req_id_t'(1'b1);
      else     ptr_q <= ptr_d;
   end
`endif

   // No grants while reset is held, even if a requester is already valid.
   assign grant      = rst ? '0 : grant_raw;
   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   // ---------------- shared ALU ----------------
   alu_req_t alu_req;
   alu_rsp_t alu_rsp;

   always_comb begin
      alu_req = '0;
      if (grant[0]) begin
         alu_req.a  = req0_a;
         alu_req.b  = req0_b;
         alu_req.op = req0_op;
      end else if (grant[1]) begin
         alu_req.a  = req1_a;
         alu_req.b  = req1_b;
         alu_req.op = req1_op;
      end
   end

   lab4_g41_p4_alu u_alu (
      .clk   (clk),
      .req_i (alu_req),
      .rsp_o (alu_rsp)
   );

   assign rsp_s    = alu_rsp.s;
   assign rsp_n    = alu_rsp.n;
   assign rsp_z    = alu_rsp.z;
   assign rsp_v    = alu_rsp.v;
   assign rsp_c    = alu_rsp.c;
   assign rsp_hata = alu_rsp.hata;

   // ---------------- tag pipeline ----------------
   // Stage i holds the tag of the op issued i cycles ago; stage ALU_LAT
   // lines up with the ALU result register.
   tag_t                 tag_in;
   tag_t [ALU_LAT:1]     tag_q, tag_d;

   assign tag_in.valid = |grant;
   assign tag_in.id    = req_id_t'(grant[1]);
   assign tag_d        = {tag_q[ALU_LAT-1:1], tag_in};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) tag_q <= '0;
      else     tag_q <= tag_d;
   end

   assign rsp0_valid = tag_q[ALU_LAT].valid & ~tag_q[ALU_LAT].id[0];
   assign rsp1_valid = tag_q[ALU_LAT].valid &  tag_q[ALU_LAT].id[0];

   always_comb begin
      busy = 1'b0;
      for (int i = 1; i <= ALU_LAT; i++) busy = busy | tag_q[i].valid;
   end

   // ---------------- saturating counters ----------------
   logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

   for (genvar r = 0; r < NUM_REQ; r++) begin : g_cnt
      always_comb begin
         cnt_d[r] = cnt_q[r];
         if (grant[r] && (cnt_q[r] != '1)) cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) cnt_q[r] <= '0;
         else     cnt_q[r] <= cnt_d[r];
      end
   end

   assign cnt0 = cnt_q[0];
   assign cnt1 = cnt_q[1];

endmodule
